// File: rtl/ifu_thrfsm_ctl_pkg.sv
// Shared thread-FSM encodings and wait-mask payload for the IFU thread scheduler.
package ifu_thrfsm_ctl_pkg;

    localparam int unsigned NTHR = 4;
    localparam int unsigned ST_W = 5;
    localparam int unsigned WM_W = 3;

    localparam logic [ST_W-1:0] THRFSM_IDLE     = 5'b00000;
    localparam logic [ST_W-1:0] THRFSM_WAIT     = 5'b10001;
    localparam logic [ST_W-1:0] THRFSM_RDY      = 5'b11001;
    localparam logic [ST_W-1:0] THRFSM_SPEC_RDY = 5'b10011;
    localparam logic [ST_W-1:0] THRFSM_RUN      = 5'b00101;
    localparam logic [ST_W-1:0] THRFSM_SPEC_RUN = 5'b00111;

    // One thread's three wait reasons; also used for set/clr event bundles.
    typedef struct packed {
        logic imiss;
        logic other;
        logic stb;
    } wm_t;

    function automatic logic thr_is_rdy(input logic [ST_W-1:0] st);
        return (st == THRFSM_RDY) || (st == THRFSM_SPEC_RDY);
    endfunction

endpackage

// File: rtl/ifu_thrfsm_ctl_if.sv
// Event inputs and state/mask outputs of the thread scheduling controller.
interface ifu_thrfsm_ctl_if;
    import ifu_thrfsm_ctl_pkg::*;

    logic [NTHR-1:0] thr_start;
    logic [NTHR-1:0] imiss_set;
    logic [NTHR-1:0] imiss_clr;
    logic [NTHR-1:0] other_set;
    logic [NTHR-1:0] other_clr;
    logic [NTHR-1:0] stb_set;
    logic [NTHR-1:0] stb_clr;
    logic [NTHR-1:0] spec_clr;
    logic [NTHR-1:0] spec_confirm;
    logic [NTHR-1:0] spec_kill;
    logic [NTHR-1:0] sw_sel;

    logic [ST_W-1:0] thr_state0;
    logic [ST_W-1:0] thr_state1;
    logic [ST_W-1:0] thr_state2;
    logic [ST_W-1:0] thr_state3;
    logic [NTHR-1:0] wm_imiss;
    logic [NTHR-1:0] wm_other;
    logic [NTHR-1:0] wm_stbwait;
    logic [NTHR-1:0] completion;
    logic [NTHR-1:0] rdy_vec;
    logic [NTHR-1:0] hang;

    modport master (
        output thr_start, imiss_set, imiss_clr, other_set, other_clr, stb_set, stb_clr,
               spec_clr, spec_confirm, spec_kill, sw_sel,
        input  thr_state0, thr_state1, thr_state2, thr_state3,
               wm_imiss, wm_other, wm_stbwait, completion, rdy_vec, hang
    );

    modport slave (
        input  thr_start, imiss_set, imiss_clr, other_set, other_clr, stb_set, stb_clr,
               spec_clr, spec_confirm, spec_kill, sw_sel,
        output thr_state0, thr_state1, thr_state2, thr_state3,
               wm_imiss, wm_other, wm_stbwait, completion, rdy_vec, hang
    );

endinterface

// File: rtl/ifu_thrfsm_thr.sv
// One hardware thread: wait masks, scheduling state, completion pulse and WAIT watchdog.
module ifu_thrfsm_thr
    import ifu_thrfsm_ctl_pkg::*;
#(
    parameter int unsigned WAIT_TMO = 4096,
    parameter int unsigned CNT_W    = 13
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            thr_start,
    input  wm_t             set,
    input  wm_t             clr,
    input  logic            spec_clr,
    input  logic            spec_confirm,
    input  logic            spec_kill,
    input  logic            sel,
    output logic [ST_W-1:0] state,
    output wm_t             wm,
    output logic            completion,
    output logic            rdy,
    output logic            hang
);

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(WAIT_TMO);
    localparam wm_t              KILL_WM = '{imiss: 1'b0, other: 1'b1, stb: 1'b0};

    logic [ST_W-1:0]  state_nxt;
    logic [WM_W-1:0]  wm_q, wm_nxt, set_v, clr_v, keep, upd;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             kill, spec_cause, comp_nxt, rdy_nxt, hang_nxt;

    assign set_v = set;
    assign clr_v = clr;
    assign wm    = wm_q;

    // Next masks and state; a non-IDLE thread is in WAIT exactly when a mask bit is set.
    always_comb begin
        state_nxt  = state;
        wm_nxt     = '0;
        kill       = spec_kill && ((state == THRFSM_SPEC_RDY) || (state == THRFSM_SPEC_RUN));
        keep       = wm_q & ~clr_v;
        upd        = set_v | (spec_clr ? '0 : keep) | (kill ? WM_W'(KILL_WM) : '0);
        spec_cause = spec_clr && (keep != '0);

        if (state == THRFSM_IDLE) begin
            if (thr_start) state_nxt = THRFSM_RDY;
        end else begin
            wm_nxt = upd;
            if (wm_nxt != '0) begin
                state_nxt = THRFSM_WAIT;
            end else begin
                case (state)
                    THRFSM_WAIT:     state_nxt = spec_cause ? THRFSM_SPEC_RDY : THRFSM_RDY;
                    THRFSM_RDY:      if (sel) state_nxt = THRFSM_RUN;
                    THRFSM_SPEC_RDY: begin
                        if (sel)               state_nxt = THRFSM_SPEC_RUN;
                        else if (spec_confirm) state_nxt = THRFSM_RDY;
                    end
                    THRFSM_RUN:      if (!sel) state_nxt = THRFSM_RDY;
                    THRFSM_SPEC_RUN: begin
                        if (!sel)              state_nxt = THRFSM_SPEC_RDY;
                        else if (spec_confirm) state_nxt = THRFSM_RUN;
                    end
                    default:         state_nxt = THRFSM_IDLE;
                endcase
            end
        end

        comp_nxt = (wm_q != '0) && (wm_nxt == '0);
        rdy_nxt  = thr_is_rdy(state_nxt);

        cnt_nxt  = '0;
        hang_nxt = hang;
        if (state == THRFSM_WAIT) begin
            cnt_nxt = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_nxt == TMO) hang_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= THRFSM_IDLE;
            wm_q       <= '0;
            completion <= 1'b0;
            rdy        <= 1'b0;
            hang       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_nxt;
            wm_q       <= wm_nxt;
            completion <= comp_nxt;
            rdy        <= rdy_nxt;
            hang       <= hang_nxt;
            cnt_q      <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ifu_thrfsm_ctl.sv
// Per-core thread scheduling controller: sw_sel fan-out, four thread FSMs, output bundling.
module ifu_thrfsm_ctl
    import ifu_thrfsm_ctl_pkg::*;
#(
    parameter int unsigned WAIT_TMO = 4096,
    parameter int unsigned CNT_W    = 13
) (
    input  logic               clk,
    input  logic               rst_l,
    ifu_thrfsm_ctl_if.slave    bus
);

    logic [NTHR-1:0] sel;
    logic            sel_ok;
    logic [ST_W-1:0] st [NTHR];
    wm_t             wm    [NTHR];
    wm_t             set_a [NTHR];
    wm_t             clr_a [NTHR];
    logic [NTHR-1:0] comp, rdy, hang;
    logic [NTHR-1:0] wm_imiss_v, wm_other_v, wm_stb_v;

    // A multi-hot select is dropped so at most one thread can ever be running.
    assign sel_ok = (bus.sw_sel & (bus.sw_sel - NTHR'(1))) == '0;
    assign sel    = sel_ok ? bus.sw_sel : '0;

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            set_a[i] = '{imiss: bus.imiss_set[i], other: bus.other_set[i], stb: bus.stb_set[i]};
            clr_a[i] = '{imiss: bus.imiss_clr[i], other: bus.other_clr[i], stb: bus.stb_clr[i]};
        end
    end

    for (genvar g = 0; g < NTHR; g++) begin : g_thr
        ifu_thrfsm_thr #(
            .WAIT_TMO (WAIT_TMO),
            .CNT_W    (CNT_W)
        ) u_thr (
            .clk          (clk),
            .rst_l        (rst_l),
            .thr_start    (bus.thr_start[g]),
            .set          (set_a[g]),
            .clr          (clr_a[g]),
            .spec_clr     (bus.spec_clr[g]),
            .spec_confirm (bus.spec_confirm[g]),
            .spec_kill    (bus.spec_kill[g]),
            .sel          (sel[g]),
            .state        (st[g]),
            .wm           (wm[g]),
            .completion   (comp[g]),
            .rdy          (rdy[g]),
            .hang         (hang[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            wm_imiss_v[i] = wm[i].imiss;
            wm_other_v[i] = wm[i].other;
            wm_stb_v[i]   = wm[i].stb;
        end
    end

    assign bus.thr_state0 = st[0];
    assign bus.thr_state1 = st[1];
    assign bus.thr_state2 = st[2];
    assign bus.thr_state3 = st[3];
    assign bus.wm_imiss   = wm_imiss_v;
    assign bus.wm_other   = wm_other_v;
    assign bus.wm_stbwait = wm_stb_v;
    assign bus.completion = comp;
    assign bus.rdy_vec    = rdy;
    assign bus.hang       = hang;

endmodule

// File: tb/tb_ifu_thrfsm_ctl.sv
// Directed plus randomized check of ifu_thrfsm_ctl against a thread-level reference model.
module tb_ifu_thrfsm_ctl;

    localparam int TMO = 16;

    typedef enum int {S_IDLE, S_WAIT, S_RDY, S_SPEC_RDY, S_RUN, S_SPEC_RUN} mst_e;

    logic clk;
    logic rst_l;

    ifu_thrfsm_ctl_if bus();

    ifu_thrfsm_ctl #(.WAIT_TMO(TMO), .CNT_W(13)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mst_e ms    [4];
    bit   mi    [4];
    bit   mo    [4];
    bit   mb    [4];
    bit   mcomp [4];
    bit   mhang [4];
    int   mcnt  [4];
    int   n_cmp;
    int   n_err;

    function automatic logic [4:0] enc(input mst_e s);
        case (s)
            S_WAIT:     return 5'b10001;
            S_RDY:      return 5'b11001;
            S_SPEC_RDY: return 5'b10011;
            S_RUN:      return 5'b00101;
            S_SPEC_RUN: return 5'b00111;
            default:    return 5'b00000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ms[i] = S_IDLE; mi[i] = 0; mo[i] = 0; mb[i] = 0;
            mcomp[i] = 0; mhang[i] = 0; mcnt[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (!rst_l) return;
        for (int i = 0; i < 4; i++) begin
            bit si = bus.imiss_set[i], ci = bus.imiss_clr[i];
            bit so = bus.other_set[i], co = bus.other_clr[i];
            bit sb = bus.stb_set[i],   cb = bus.stb_clr[i];
            bit sc = bus.spec_clr[i],  sk = bus.spec_kill[i], cf = bus.spec_confirm[i];
            bit sel = bus.sw_sel[i];
            mst_e s = ms[i];
            mst_e ns = s;
            bit any_old = mi[i] | mo[i] | mb[i];
            bit ni = 0, no = 0, nb = 0, kill;

            if (s == S_WAIT) begin
                if (mcnt[i] < TMO) mcnt[i]++;
                if (mcnt[i] == TMO) mhang[i] = 1;
            end else begin
                mcnt[i] = 0;
            end

            if (s == S_IDLE) begin
                if (bus.thr_start[i]) ns = S_RDY;
            end else begin
                kill = sk && (s == S_SPEC_RDY || s == S_SPEC_RUN);
                ni = si | (mi[i] & !ci & !sc);
                no = so | (mo[i] & !co & !sc) | kill;
                nb = sb | (mb[i] & !cb & !sc);
                if (ni | no | nb)                  ns = S_WAIT;
                else if (s == S_WAIT)
                    ns = (sc && ((mi[i] & !ci) | (mo[i] & !co) | (mb[i] & !cb))) ? S_SPEC_RDY : S_RDY;
                else if (s == S_RDY && sel)        ns = S_RUN;
                else if (s == S_SPEC_RDY && sel)   ns = S_SPEC_RUN;
                else if (s == S_RUN && !sel)       ns = S_RDY;
                else if (s == S_SPEC_RUN && !sel)  ns = S_SPEC_RDY;
                else if (cf && s == S_SPEC_RDY)    ns = S_RDY;
                else if (cf && s == S_SPEC_RUN)    ns = S_RUN;
            end
            mcomp[i] = any_old && !(ni | no | nb);
            ms[i] = ns; mi[i] = ni; mo[i] = no; mb[i] = nb;
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_i, e_o, e_b, e_c, e_r, e_h;
        chk("thr_state0", 32'(bus.thr_state0), 32'(enc(ms[0])));
        chk("thr_state1", 32'(bus.thr_state1), 32'(enc(ms[1])));
        chk("thr_state2", 32'(bus.thr_state2), 32'(enc(ms[2])));
        chk("thr_state3", 32'(bus.thr_state3), 32'(enc(ms[3])));
        for (int i = 0; i < 4; i++) begin
            e_i[i] = mi[i]; e_o[i] = mo[i]; e_b[i] = mb[i];
            e_c[i] = mcomp[i]; e_h[i] = mhang[i];
            e_r[i] = (ms[i] == S_RDY) || (ms[i] == S_SPEC_RDY);
        end
        chk("wm_imiss",   32'(bus.wm_imiss),   32'(e_i));
        chk("wm_other",   32'(bus.wm_other),   32'(e_o));
        chk("wm_stbwait", 32'(bus.wm_stbwait), 32'(e_b));
        chk("completion", 32'(bus.completion), 32'(e_c));
        chk("rdy_vec",    32'(bus.rdy_vec),    32'(e_r));
        chk("hang",       32'(bus.hang),       32'(e_h));
    endtask

    task automatic clr_in();
        bus.thr_start = '0; bus.imiss_set = '0; bus.imiss_clr = '0;
        bus.other_set = '0; bus.other_clr = '0; bus.stb_set = '0; bus.stb_clr = '0;
        bus.spec_clr = '0; bus.spec_confirm = '0; bus.spec_kill = '0; bus.sw_sel = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset dropped mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        #3;
        rst_l = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        clr_in();
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    function automatic logic [3:0] rnd4(input int unsigned p);
        logic [3:0] v;
        for (int j = 0; j < 4; j++) v[j] = ($urandom_range(p - 1) == 0);
        return v;
    endfunction

    task automatic rand_in();
        int cand[$];
        int r;
        bus.thr_start    = rnd4(8);
        bus.imiss_set    = rnd4(10);
        bus.imiss_clr    = rnd4(4);
        bus.other_set    = rnd4(12);
        bus.other_clr    = rnd4(4);
        bus.stb_set      = rnd4(12);
        bus.stb_clr      = rnd4(4);
        bus.spec_clr     = rnd4(16);
        bus.spec_confirm = rnd4(8);
        bus.spec_kill    = rnd4(16);
        r = int'($urandom_range(3));
        if (r == 0) begin
            bus.sw_sel = '0;
        end else if (r == 1) begin
            bus.sw_sel = 4'b0001 << $urandom_range(3);
        end else begin
            for (int i = 0; i < 4; i++)
                if (ms[i] inside {S_RDY, S_SPEC_RDY, S_RUN, S_SPEC_RUN}) cand.push_back(i);
            bus.sw_sel = (cand.size() == 0) ? 4'b0000
                       : 4'b0001 << cand[$urandom_range(cand.size() - 1)];
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_l = 1'b0;
        clr_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_l = 1'b1;

        // T0: start, run, I-miss, fill return
        bus.thr_start = 4'b0001; step();
        bus.thr_start = 4'b0000; bus.sw_sel = 4'b0001; step();
        bus.imiss_set = 4'b0001; step();
        chk("t0_wait_mask", 32'(bus.wm_imiss), 32'h1);
        bus.imiss_set = 4'b0000; step(); step();
        bus.imiss_clr = 4'b0001; step();
        chk("t0_completion", 32'(bus.completion), 32'h1);
        bus.imiss_clr = 4'b0000; step();
        clr_in(); step();

        // T1: clear of one reason with a same-cycle set of another
        bus.thr_start = 4'b0010; step();
        clr_in(); bus.other_set = 4'b0010; step();
        clr_in(); bus.other_clr = 4'b0010; bus.stb_set = 4'b0010; step();
        chk("t1_no_comp", 32'(bus.completion), 32'h0);
        clr_in(); step();
        bus.stb_clr = 4'b0010; step();
        clr_in(); step();

        // T2: speculative clear, then kill; again with confirm
        bus.thr_start = 4'b0100; step();
        clr_in(); bus.other_set = 4'b0100; step();
        clr_in(); bus.spec_clr = 4'b0100; step();
        clr_in(); bus.sw_sel = 4'b0100; step();
        bus.spec_kill = 4'b0100; step();
        chk("t2_kill_other", 32'(bus.wm_other), 32'h4);
        bus.spec_kill = 4'b0000; bus.spec_clr = 4'b0100; step();
        bus.spec_clr = 4'b0000; step();
        bus.spec_confirm = 4'b0100; step();
        chk("t2_confirm_run", 32'(bus.thr_state2), 32'h05);
        clr_in(); step();

        // T3: watchdog
        bus.thr_start = 4'b1000; step();
        clr_in(); bus.other_set = 4'b1000; step();
        clr_in();
        repeat (TMO + 4) step();
        bus.other_clr = 4'b1000; step();
        clr_in();
        repeat (3) step();
        chk("t3_hang_sticky", 32'(bus.hang[3]), 32'h1);

        // Reset while T0 runs and T1 waits
        bus.thr_start = 4'b0011; step();
        clr_in(); bus.sw_sel = 4'b0001; bus.other_set = 4'b0010; step();
        bus.other_set = 4'b0000;
        do_reset();
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_in();
            step();
            if (n == 1500) do_reset();
        end
        clr_in();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
